// File: rtl/gsim_b_loader.sv
// Ping-pong b-vector buffer for the Gauss-Seidel solver: replays each
// stored vector as an unbroken N-cycle burst once the solver is idle.
module gsim_b_loader #(
    parameter int N  = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          gs_in_en,
    output logic [DW-1:0] gs_b,
    input  logic          gs_out_valid,
    output logic          busy,
    output logic          vec_done,
    output logic          err_len
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW-1:0] FIRST = '0;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    logic [DW-1:0] r_mem [2][N];
    state_t        r_state;
    state_t        w_state_nx;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [IW-1:0] r_out_cnt;
    logic [1:0]    r_bank_full;
    logic          r_gs_in_en;
    logic [DW-1:0] r_gs_b;
    logic          r_vec_done;
    logic          r_err_len;

    logic [IW-1:0] w_rd_idx_nx;
    logic [IW-1:0] w_out_cnt_nx;
    logic          w_in_en_nx;
    logic [DW-1:0] w_gs_b_nx;
    logic          w_vec_done_nx;
    logic          w_clr;
    logic          w_accept;
    logic          w_wr_end;
    logic          w_short;
    logic          w_long;
    logic [1:0]    w_set_mask;
    logic [1:0]    w_clr_mask;

    assign s_ready  = !r_bank_full[r_wr_bank];
    assign w_accept = s_valid && s_ready;
    assign w_wr_end = w_accept && (r_wr_idx == LAST);
    assign w_short  = w_accept && s_last && (r_wr_idx != LAST);
    assign w_long   = w_wr_end && !s_last;

    // Set and clear always target different banks, so both may apply.
    assign w_set_mask = w_wr_end ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_mask = w_clr ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][r_wr_idx] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_bank_full <= 2'b00;
            r_err_len   <= 1'b0;
        end else begin
            r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
            if (w_short || w_long) begin
                r_err_len <= 1'b1;
            end
            if (w_wr_end) begin
                r_wr_bank <= !r_wr_bank;
                r_wr_idx  <= '0;
            end else if (w_short) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_rd_idx_nx   = r_rd_idx;
        w_out_cnt_nx  = r_out_cnt;
        w_in_en_nx    = 1'b0;
        w_gs_b_nx     = '0;
        w_vec_done_nx = 1'b0;
        w_clr         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nx  = SEND;
                    w_rd_idx_nx = FIRST;
                    w_in_en_nx  = 1'b1;
                    w_gs_b_nx   = r_mem[r_rd_bank][FIRST];
                end
            end
            SEND: begin
                if (r_rd_idx == LAST) begin
                    w_clr        = 1'b1;
                    w_state_nx   = WAIT;
                    w_out_cnt_nx = '0;
                end else begin
                    w_rd_idx_nx = r_rd_idx + 1'b1;
                    w_in_en_nx  = 1'b1;
                    w_gs_b_nx   = r_mem[r_rd_bank][w_rd_idx_nx];
                end
            end
            WAIT: begin
                if (gs_out_valid) begin
                    if (r_out_cnt == LAST) begin
                        w_state_nx    = IDLE;
                        w_vec_done_nx = 1'b1;
                    end else begin
                        w_out_cnt_nx = r_out_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_out_cnt  <= '0;
            r_gs_in_en <= 1'b0;
            r_gs_b     <= '0;
            r_vec_done <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rd_idx   <= w_rd_idx_nx;
            r_out_cnt  <= w_out_cnt_nx;
            r_gs_in_en <= w_in_en_nx;
            r_gs_b     <= w_gs_b_nx;
            r_vec_done <= w_vec_done_nx;
            if (w_clr) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

    assign gs_in_en = r_gs_in_en;
    assign gs_b     = r_gs_b;
    assign busy     = (r_state != IDLE);
    assign vec_done = r_vec_done;
    assign err_len  = r_err_len;
endmodule

// File: tb/tb_gsim_b_loader.sv
// Scoreboard bench for gsim_b_loader: expected burst words are queued as
// vectors are committed and popped by a monitor on every gs_in_en cycle.
module tb_gsim_b_loader;
    localparam int N  = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          gs_out_valid = 1'b0;
    logic          s_ready;
    logic          gs_in_en;
    logic [DW-1:0] gs_b;
    logic          busy;
    logic          vec_done;
    logic          err_len;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int run = 0;
    int cyc = 0;
    int last_ov = -100;
    bit have_ov = 1'b0;
    int n_done = 0;
    int n_words = 0;

    always #5 clk = ~clk;

    gsim_b_loader #(.N(N), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .gs_in_en(gs_in_en),
        .gs_b(gs_b),
        .gs_out_valid(gs_out_valid),
        .busy(busy),
        .vec_done(vec_done),
        .err_len(err_len)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every burst word.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            run = 0;
            have_ov = 1'b0;
        end else begin
            if (vec_done) n_done++;
            if (gs_in_en) begin
                if (run == 0 && have_ov)
                    chk("launch_gap_ge2", 32'(cyc - last_ov >= 2), 1);
                run++;
                n_words++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             gs_b);
                end else begin
                    chk("gs_b", 32'(gs_b), 32'(exp_q.pop_front()));
                end
            end else if (run > 0) begin
                chk("burst_len", run, N);
                chk("gs_b_idle", 32'(gs_b), 0);
                run = 0;
            end
            if (gs_out_valid) begin
                last_ov = cyc;
                have_ov = 1'b1;
            end
        end
    end

    task automatic send_vec(input logic [DW-1:0] base, input int len,
                            input bit last_end, input int maxgap,
                            input bit push, output int stalls);
        logic [DW-1:0] w[$];
        int g;
        int t;
        bit acc;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (g > 0) begin
                s_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = base + DW'(i);
            s_last  = last_end && (i == len - 1);
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                t++;
                if (!acc && t > 400) begin
                    n_errors++;
                    $display("FAIL s_ready_timeout: got 0 expected 1");
                    $fatal(1, "source stalled");
                end
            end
            w.push_back(base + DW'(i));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (push) foreach (w[k]) exp_q.push_back(w[k]);
    endtask

    task automatic wait_burst(input string name);
        int t;
        t = 0;
        while (!gs_in_en && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_start"}, 32'(gs_in_en), 1);
        t = 0;
        while (gs_in_en && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_end"}, 32'(gs_in_en), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ov(input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            if (gapped && (i % 3 == 1)) begin
                gs_out_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            gs_out_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        gs_out_valid = 1'b0;
    endtask

    initial begin
        int st;
        int d0;
        int t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_gs_in_en", 32'(gs_in_en), 0);
        chk("rst_gs_b", 32'(gs_b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vec_done", 32'(vec_done), 0);
        chk("rst_err_len", 32'(err_len), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single vector 1..16
        d0 = n_done;
        send_vec(16'd1, N, 1'b1, 0, 1'b1, st);
        chk("t1_no_stall", st, 0);
        wait_burst("t1_burst");
        chk("t1_busy_wait", 32'(busy), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_busy_hold", 32'(busy), 1);
        chk("t1_no_done_yet", n_done - d0, 0);
        drive_ov(N, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_done", n_done - d0, 1);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_err_len", 32'(err_len), 0);

        // back-pressure: A, B, C back-to-back, no solver completion
        d0 = n_done;
        send_vec(16'h0100, N, 1'b1, 0, 1'b1, st);
        chk("t2_A_stall", st, 0);
        send_vec(16'h0200, N, 1'b1, 0, 1'b1, st);
        chk("t2_B_stall", st, 0);
        send_vec(16'h0300, N, 1'b1, 0, 1'b1, st);
        chk("t2_C_stalled", 32'(st > 0), 1);
        chk("t2_both_full", 32'(s_ready), 0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_q_BC", exp_q.size(), 2 * N);
        repeat (20) @(posedge clk);
        #1;
        chk("t2_B_held", exp_q.size(), 2 * N);
        drive_ov(N, 1'b0);
        wait_burst("t2_B");
        drive_ov(N, 1'b0);
        wait_burst("t2_C");
        drive_ov(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_done", n_done - d0, 3);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_s_ready", 32'(s_ready), 1);

        // bursty source, gapped solver completion
        d0 = n_done;
        send_vec(16'h0700, N, 1'b1, 5, 1'b1, st);
        wait_burst("t3_burst");
        drive_ov(N, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_done", n_done - d0, 1);

        // length errors
        d0 = n_done;
        send_vec(16'h0400, 10, 1'b1, 0, 1'b0, st);
        chk("t4_err_short", 32'(err_len), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_launch", 32'(busy), 0);
        send_vec(16'h0500, N, 1'b1, 0, 1'b1, st);
        wait_burst("t4_good");
        drive_ov(N, 1'b0);
        send_vec(16'h0600, N, 1'b0, 0, 1'b1, st);
        wait_burst("t4_long");
        chk("t4_err_sticky", 32'(err_len), 1);
        drive_ov(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done", n_done - d0, 2);

        // reset at the 7th burst cycle
        send_vec(16'h0800, N, 1'b1, 0, 1'b1, st);
        t = 0;
        st = 0;
        while (st < 7 && t < 300) begin
            @(negedge clk);
            if (gs_in_en) st++;
            t++;
        end
        chk("t5_reached_7", st, 7);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_in_en", 32'(gs_in_en), 0);
        chk("t5_rst_gs_b", 32'(gs_b), 0);
        chk("t5_rst_s_ready", 32'(s_ready), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_err_len", 32'(err_len), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        d0 = n_done;
        send_vec(16'h0900, N, 1'b1, 0, 1'b1, st);
        wait_burst("t5_fresh");
        drive_ov(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_done", n_done - d0, 1);
        chk("t5_idle", 32'(busy), 0);

        chk("q_empty", exp_q.size(), 0);
        chk("total_words", n_words, 16 + 48 + 16 + 32 + 7 + 16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
